// File: rtl/vmm_pkg.sv
// Shared definitions for the VMM datapath.
//   DATA_W   : component width (Q1.15, two's complement)
//   SAT_MAX  : largest representable Q1.15 value
//   SAT_MIN  : smallest representable Q1.15 value
//   state_e  : row accumulator state encoding
package vmm_pkg;

    localparam int unsigned DATA_W = 16;

    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/vmm_sat_trunc.sv
// Combinational saturating narrower: IN_W-bit signed value to OUT_W-bit signed value.
//   din  in  IN_W   wide two's complement value
//   dout out OUT_W  clamped value
//   sat  out 1      din was outside the OUT_W range and was clamped
module vmm_sat_trunc #(
    parameter int unsigned IN_W  = 18,
    parameter int unsigned OUT_W = 16
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             sat
);

    // The value fits iff all bits from the output sign bit upward agree.
    logic [IN_W-OUT_W:0] upper;
    logic                fits;

    assign upper = din[IN_W-1:OUT_W-1];
    assign fits  = (&upper) || (~|upper);

    always_comb begin
        sat  = !fits;
        dout = din[OUT_W-1:0];
        if (!fits) begin
            dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/vmm_row_accumulator.sv
// Complex multiply-accumulate output stage. Sums VEC_LEN complex beats into one
// saturated complex result per row.
//   CLK        in   system clock (rising edge)
//   rst        in   synchronous active-high reset
//   in_valid   in   input beat valid
//   in_ready   out  block can accept a beat (state only)
//   in_real    in   real part of partial product
//   in_imag    in   imaginary part of partial product
//   in_last    in   upstream end-of-row marker (checked, not used for framing)
//   out_valid  out  result valid
//   out_ready  in   downstream accepts the result
//   out_real   out  saturated real sum
//   out_imag   out  saturated imaginary sum
//   out_sat    out  either component saturated for this result
//   err_len    out  sticky: in_last disagreed with the beat count
module vmm_row_accumulator #(
    parameter int unsigned VEC_LEN = 8,
    parameter int unsigned DATA_W  = vmm_pkg::DATA_W,
    parameter int unsigned CNT_W   = $clog2(VEC_LEN),
    parameter int unsigned ACC_W   = DATA_W + CNT_W
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic              out_sat,
    output logic              err_len
);

    import vmm_pkg::*;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

    state_e                    state_q;
    logic [CNT_W-1:0]          count_q;
    logic signed [ACC_W-1:0]   acc_real_q;
    logic signed [ACC_W-1:0]   acc_imag_q;

    logic signed [ACC_W-1:0]   sum_real;
    logic signed [ACC_W-1:0]   sum_imag;
    logic [DATA_W-1:0]         sat_real;
    logic [DATA_W-1:0]         sat_imag;
    logic                      sat_real_flag;
    logic                      sat_imag_flag;
    logic                      accept;
    logic                      last_beat;

    assign in_ready  = (state_q == ACCUM);
    assign accept    = in_valid && in_ready;
    assign last_beat = (count_q == LAST_CNT);

    assign sum_real = acc_real_q + {{CNT_W{in_real[DATA_W-1]}}, in_real};
    assign sum_imag = acc_imag_q + {{CNT_W{in_imag[DATA_W-1]}}, in_imag};

    vmm_sat_trunc #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_W)
    ) u_sat_real (
        .din  (sum_real),
        .dout (sat_real),
        .sat  (sat_real_flag)
    );

    vmm_sat_trunc #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_W)
    ) u_sat_imag (
        .din  (sum_imag),
        .dout (sat_imag),
        .sat  (sat_imag_flag)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q    <= ACCUM;
            count_q    <= '0;
            acc_real_q <= '0;
            acc_imag_q <= '0;
            out_valid  <= 1'b0;
            out_real   <= '0;
            out_imag   <= '0;
            out_sat    <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (accept) begin
                        // Framing follows the counter; in_last only feeds the error flag.
                        if (in_last != last_beat) begin
                            err_len <= 1'b1;
                        end
                        if (last_beat) begin
                            out_real   <= sat_real;
                            out_imag   <= sat_imag;
                            out_sat    <= sat_real_flag || sat_imag_flag;
                            out_valid  <= 1'b1;
                            acc_real_q <= '0;
                            acc_imag_q <= '0;
                            count_q    <= '0;
                            state_q    <= HOLD;
                        end else begin
                            acc_real_q <= sum_real;
                            acc_imag_q <= sum_imag;
                            count_q    <= count_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Result data stays on the bus after the handshake; only valid drops.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_vmm_row_accumulator.sv
module tb_vmm_row_accumulator;

    import vmm_pkg::*;

    localparam int VEC = 4;

    logic        CLK = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_real;
    logic [15:0] in_imag;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_real;
    logic [15:0] out_imag;
    logic        out_sat;
    logic        err_len;

    always #5 CLK = ~CLK;

    vmm_row_accumulator #(
        .VEC_LEN (VEC)
    ) dut (
        .CLK       (CLK),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_sat   (out_sat),
        .err_len   (err_len)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the current row is a list of accepted beats; a result is
    // the clamped plain-integer sum once the list holds VEC entries.
    int row_re[$];
    int row_im[$];
    bit m_hold;
    bit m_valid;
    int m_out_re;
    int m_out_im;
    bit m_sat;
    bit m_err;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp16(input int s);
        if (s > int'(SAT_MAX)) return int'(SAT_MAX);
        if (s < int'(SAT_MIN)) return int'(SAT_MIN);
        return s;
    endfunction

    function automatic int rand_val();
        int sel;
        sel = int'($urandom_range(0, 5));
        if (sel == 0) return int'(SAT_MAX);
        if (sel == 1) return int'(SAT_MIN);
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic model_step(input bit r, input bit v, input int re, input int im,
                              input bit last, input bit ordy);
        int sr;
        int si;
        if (r) begin
            row_re.delete();
            row_im.delete();
            m_hold   = 1'b0;
            m_valid  = 1'b0;
            m_out_re = 0;
            m_out_im = 0;
            m_sat    = 1'b0;
            m_err    = 1'b0;
        end else if (!m_hold) begin
            if (v) begin
                row_re.push_back(re);
                row_im.push_back(im);
                if (last != (row_re.size() == VEC)) m_err = 1'b1;
                if (row_re.size() == VEC) begin
                    sr = 0;
                    si = 0;
                    foreach (row_re[i]) begin
                        sr += row_re[i];
                        si += row_im[i];
                    end
                    m_out_re = clamp16(sr);
                    m_out_im = clamp16(si);
                    m_sat    = (sr != m_out_re) || (si != m_out_im);
                    m_valid  = 1'b1;
                    m_hold   = 1'b1;
                    row_re.delete();
                    row_im.delete();
                end
            end
        end else if (ordy) begin
            m_valid = 1'b0;
            m_hold  = 1'b0;
        end
    endtask

    // Called at a falling edge: drive, advance the model, clock, compare.
    task automatic cycle(input bit r, input bit v, input int re, input int im,
                         input bit last, input bit ordy);
        rst       = r;
        in_valid  = v;
        in_real   = re[15:0];
        in_imag   = im[15:0];
        in_last   = last;
        out_ready = ordy;
        model_step(r, v, re, im, last, ordy);
        @(posedge CLK);
        @(negedge CLK);
        check("in_ready", int'(in_ready), int'(!m_hold));
        check("out_valid", int'(out_valid), int'(m_valid));
        check("out_real", int'($signed(out_real)), m_out_re);
        check("out_imag", int'($signed(out_imag)), m_out_im);
        check("out_sat", int'(out_sat), int'(m_sat));
        check("err_len", int'(err_len), int'(m_err));
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 1'b0, 0, 0, 1'b0, ordy);
    endtask

    task automatic beat(input int re, input int im, input bit last);
        cycle(1'b0, 1'b1, re, im, last, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_real   = '0;
        in_imag   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        m_hold    = 1'b0;
        @(negedge CLK);
        cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        check("reset_valid", int'(out_valid), 0);
        check("reset_ready", int'(in_ready), 1);

        // Basic row, one-cycle bubble.
        for (int i = 1; i <= 4; i++) beat(i, -i, i == 4);
        check("t1_valid", int'(out_valid), 1);
        check("t1_real", int'($signed(out_real)), 10);
        check("t1_imag", int'($signed(out_imag)), -10);
        check("t1_sat", int'(out_sat), 0);
        check("t1_bubble", int'(in_ready), 0);
        idle(1'b1);
        check("t1_ready_back", int'(in_ready), 1);
        check("t1_err", int'(err_len), 0);

        // Saturation in both directions, then a clean row.
        for (int i = 1; i <= 4; i++) beat(32767, -32768, i == 4);
        check("t2_real", int'($signed(out_real)), 32767);
        check("t2_imag", int'($signed(out_imag)), -32768);
        check("t2_sat", int'(out_sat), 1);
        idle(1'b1);
        for (int i = 1; i <= 4; i++) beat(1, 0, i == 4);
        check("t2b_real", int'($signed(out_real)), 4);
        check("t2b_sat", int'(out_sat), 0);

        // Backpressure: beats offered during HOLD must not be consumed.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 100, 100, 1'b0, 1'b0);
        check("t3_held_real", int'($signed(out_real)), 4);
        check("t3_held_valid", int'(out_valid), 1);
        idle(1'b1);
        for (int i = 1; i <= 4; i++) beat(-7, 3 * i, i == 4);
        check("t3_real", int'($signed(out_real)), -28);
        check("t3_imag", int'($signed(out_imag)), 30);
        idle(1'b1);

        // Reset mid-row discards the partial sum.
        beat(1000, 1000, 1'b0);
        beat(1000, 1000, 1'b0);
        cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        check("t4_rst_real", int'($signed(out_real)), 0);
        check("t4_rst_valid", int'(out_valid), 0);
        for (int i = 1; i <= 4; i++) beat(5, 5, i == 4);
        check("t4_real", int'($signed(out_real)), 20);
        check("t4_imag", int'($signed(out_imag)), 20);
        idle(1'b1);

        // Early in_last: flag sets and sticks, framing still by count.
        beat(2, 1, 1'b0);
        beat(2, 1, 1'b0);
        beat(2, 1, 1'b1);
        check("t5_err_set", int'(err_len), 1);
        check("t5_no_early", int'(out_valid), 0);
        beat(2, 1, 1'b0);
        check("t5_real", int'($signed(out_real)), 8);
        check("t5_imag", int'($signed(out_imag)), 4);
        idle(1'b1);
        check("t5_err_sticky", int'(err_len), 1);

        // Clear the flag, then random rows with gaps and random backpressure.
        cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int row = 0; row < 30; row++) begin
            for (int b = 1; b <= VEC; b++) begin
                for (int guard = 0; m_hold && guard < 50; guard++) begin
                    cycle(1'b0, 1'($urandom_range(0, 1)), rand_val(), rand_val(), 1'b0,
                          1'($urandom_range(0, 1)));
                end
                if (m_hold) check("t6_hold_timeout", int'(out_valid), 0);
                for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                    idle(1'($urandom_range(0, 1)));
                end
                cycle(1'b0, 1'b1, rand_val(), rand_val(), b == VEC, 1'($urandom_range(0, 1)));
            end
        end
        idle(1'b1);
        check("t6_err", int'(err_len), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
